// File: rtl/adder_pkg.sv
// Shared constants and operand-mode encoding
// for the segmented pipelined adder.
package adder_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_SEG   = 4;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } mode_e;

endpackage

// File: rtl/adder_segment.sv
// One SEG-bit slice of the ripple chain: sum, carry out,
// and the carry into the slice MSB for overflow detection.
module adder_segment
    import adder_pkg::*;
#(
    parameter int SEG = DEF_SEG
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           c_in,
    output logic [SEG-1:0] sum,
    output logic           c_out,
    output logic           c_pen
);

    logic [SEG:0] full;

    assign full  = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, c_in};
    assign sum   = full[SEG-1:0];
    assign c_out = full[SEG];
    // carry into the MSB falls out of the MSB sum bit
    assign c_pen = full[SEG-1] ^ a[SEG-1] ^ b[SEG-1];

endmodule

// File: rtl/pipelined_adder.sv
// Segmented adder: one SEG-bit slice per stage, all stages
// advancing together under a single valid/ready stall.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int STAGES = WIDTH / SEG;

    if (SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of SEG");
    end

    mode_e            mode;
    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    assign mode     = mode_e'(sub);
    assign b_eff    = (mode == SUB) ? ~b : b;
    assign c_eff    = (mode == SUB) ? 1'b1 : c_in;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Each stage sees the operand bits not yet added (low slice
    // first) and the sum bits already finished below it.
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int HI = WIDTH - k * SEG;

        logic [HI-1:0]          a_s;
        logic [HI-1:0]          b_s;
        logic                   c_s;
        logic                   v_s;
        logic [SEG-1:0]         seg_s;
        logic                   co_s;
        logic                   cp_s;
        logic [(k+1)*SEG-1:0]   acc_s;

        adder_segment #(
            .SEG   (SEG)
        ) u_seg (
            .a     (a_s[SEG-1:0]),
            .b     (b_s[SEG-1:0]),
            .c_in  (c_s),
            .sum   (seg_s),
            .c_out (co_s),
            .c_pen (cp_s)
        );

        if (k == 0) begin : g_head
            assign a_s   = a;
            assign b_s   = b_eff;
            assign c_s   = c_eff;
            assign v_s   = in_valid;
            assign acc_s = seg_s;
        end else begin : g_body
            logic [k*SEG-1:0] s_r;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_s <= 1'b0;
                    c_s <= 1'b0;
                    a_s <= '0;
                    b_s <= '0;
                    s_r <= '0;
                end else if (en) begin
                    v_s <= g_st[k-1].v_s;
                    c_s <= g_st[k-1].co_s;
                    a_s <= g_st[k-1].a_s[HI+SEG-1:SEG];
                    b_s <= g_st[k-1].b_s[HI+SEG-1:SEG];
                    s_r <= g_st[k-1].acc_s;
                end
            end

            assign acc_s = {seg_s, s_r};
        end

        if (k != STAGES - 1) begin : g_mid
            logic cp_unused;
            assign cp_unused = cp_s;
        end
    end

    logic last_v;
    logic last_co;
    logic last_cp;

    assign last_v  = g_st[STAGES-1].v_s;
    assign last_co = g_st[STAGES-1].co_s;
    assign last_cp = g_st[STAGES-1].cp_s;

    // Bubbles clear out_valid but leave the result fields alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
        end else if (en) begin
            out_valid <= last_v;
            if (last_v) begin
                sum   <= g_st[STAGES-1].acc_s;
                c_out <= last_co;
                ovf   <= last_co ^ last_cp;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and randomized bench for pipelined_adder
// (WIDTH=8, SEG=4) with a queue-based reference.
module tb_pipelined_adder;

    localparam int W = 8;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         c_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;

    int           errors = 0;
    int           checks = 0;
    logic [9:0]   exp_q[$];
    logic [9:0]   pending = '0;
    logic [W-1:0] held;

    always #5 clk = ~clk;

    pipelined_adder #(
        .WIDTH     (W),
        .SEG       (S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    function automatic logic [9:0] pk(int s, bit c, bit o);
        logic [7:0] s8;
        s8 = s[7:0];
        return {o, c, s8};
    endfunction

    // Reference: plain integer arithmetic, unsigned and signed views.
    function automatic logic [9:0] model(logic [7:0] x, logic [7:0] y,
                                         logic s, logic ci);
        int ux, uy, sx, sy, full, sr;
        ux = x;
        uy = y;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            full = ux + (255 - uy) + 1;
            sr   = sx - sy;
        end else begin
            full = ux + uy + int'(ci);
            sr   = sx + sy + int'(ci);
        end
        return pk(full % 256, full > 255, (sr > 127) || (sr < -128));
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(int x, int y, bit s, bit ci, logic [9:0] e);
        a        = x[W-1:0];
        b        = y[W-1:0];
        sub      = s;
        c_in     = ci;
        in_valid = 1'b1;
        pending  = e;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // One clock: score transfers on the falling edge, return at posedge+1.
    task automatic tick();
        logic [9:0] e;
        @(negedge clk);
        if (out_valid === 1'b1 && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sum", 32'(sum), 32'(e[7:0]));
                chk("c_out", 32'(c_out), 32'(e[8]));
                chk("ovf", 32'(ovf), 32'(e[9]));
            end
        end
        if (in_valid && in_ready === 1'b1)
            exp_q.push_back(pending);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++)
            tick();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int av[4];
        int bv[4];
        int sv[4];
        av = '{2, 12, 27, 18};
        bv = '{8, 14, 13, 32};
        sv = '{10, 26, 40, 50};

        out_ready = 1'b1;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_c_out", 32'(c_out), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // two-cycle latency
        send(2, 3, 1'b0, 1'b0, pk(5, 0, 0));
        tick();
        idle();
        chk("lat_cycle1_valid", 32'(out_valid), 32'd0);
        tick();
        chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
        chk("lat_cycle2_sum", 32'(sum), 32'd5);
        drain();

        // carry, overflow and subtraction corners
        send(200, 100, 1'b0, 1'b0, pk(44, 1, 0));
        tick();
        send(112, 20, 1'b0, 1'b0, pk(132, 0, 1));
        tick();
        send(12, 14, 1'b1, 1'b0, pk(254, 0, 0));
        tick();
        send(27, 13, 1'b1, 1'b1, pk(14, 1, 0));
        tick();
        drain();

        // back-to-back results on consecutive cycles
        for (int i = 0; i < 5; i++) begin
            if (i < 4)
                send(av[i], bv[i], 1'b0, 1'b0, pk(sv[i], 0, 0));
            else
                idle();
            tick();
            if (i >= 1) begin
                chk("b2b_valid", 32'(out_valid), 32'd1);
                chk("b2b_sum", 32'(sum), 32'(sv[i-1]));
            end
        end
        drain();

        // full pipeline under backpressure
        out_ready = 1'b0;
        send(100, 27, 1'b0, 1'b0, pk(127, 0, 0));
        tick();
        send(5, 9, 1'b1, 1'b0, pk(252, 0, 0));
        tick();
        send(60, 70, 1'b0, 1'b1, pk(131, 0, 1));
        held = sum;
        chk("stall_first_sum", 32'(held), 32'd127);
        for (int i = 0; i < 5; i++) begin
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_sum_hold", 32'(sum), 32'(held));
            tick();
        end
        out_ready = 1'b1;
        tick();
        drain();

        // reset with two results in flight
        send(1, 1, 1'b0, 1'b0, pk(2, 0, 0));
        tick();
        send(3, 4, 1'b0, 1'b0, pk(7, 0, 0));
        tick();
        idle();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_sum", 32'(sum), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("no_stale_valid", 32'(out_valid), 32'd0);
            tick();
        end

        // randomized traffic with random stalls
        for (int i = 0; i < 400; i++) begin
            logic [7:0] ra, rb;
            logic rs, rc;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            rc = 1'($urandom);
            send(int'(ra), int'(rb), rs, rc, model(ra, rb, rs, rc));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
